// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, credit-limited imem reads, in-order fetch queue to dispatch; FETCH_BYPASS_EN adds same-cycle response forwarding.
// Latency: request at t, response at t+L, out_fetch_valid at t+L+1 (t+L with FETCH_BYPASS_EN and an empty queue).
// Backpressure: in_stall holds the queue head; requests stop when queued plus in-flight words reach FQ_DEPTH.
module fetch_unit #(
    parameter int unsigned FQ_DEPTH = 4,
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter logic [31:0] HLT_INSN = 32'hD440_0000
) (
    input  logic        in_clk,
    input  logic        in_rst,
    input  logic        in_start,
    output logic        out_imem_req_valid,
    output logic [63:0] out_imem_addr,
    input  logic        in_imem_resp_valid,
    input  logic [31:0] in_imem_rdata,
    output logic        out_fetch_valid,
    output logic [31:0] out_insnbits,
    output logic [63:0] out_pc,
    input  logic        in_stall,
    output logic        out_fetch_done,
    input  logic        in_redirect,
    input  logic [63:0] in_redirect_pc
);
    localparam int unsigned AW = $clog2(FQ_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(FQ_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_n;

    logic [63:0]   pc;
    logic [31:0]   fq_insn [FQ_DEPTH];
    logic [63:0]   fq_pc   [FQ_DEPTH];
    logic [AW-1:0] fq_head, fq_tail;
    logic [CW-1:0] fq_count;
    logic [63:0]   pcf     [FQ_DEPTH];
    logic [AW-1:0] pcf_head, pcf_tail;
    logic [CW-1:0] outstanding, squash;

    logic          redirect, resp_live, hlt_in, hlt_out, req, enq, deq, pop, bypass;
    logic [CW:0]   credit_used;

    assign redirect    = in_redirect && (state != IDLE);
    assign resp_live   = in_imem_resp_valid && (squash == '0) && !redirect;
    assign hlt_in      = resp_live && (in_imem_rdata == HLT_INSN);
    assign credit_used = {1'b0, fq_count} + {1'b0, outstanding};
    // The HLT response itself shuts off requests in its arrival cycle.
    assign req         = (state == RUN) && !redirect && !hlt_in && (credit_used < DEPTH_W);

`ifdef FETCH_BYPASS_EN
    assign bypass = resp_live && (fq_count == '0);
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        out_fetch_valid = 1'b0;
        out_insnbits    = '0;
        out_pc          = '0;
        if (fq_count != '0) begin
            out_fetch_valid = 1'b1;
            out_insnbits    = fq_insn[fq_head];
            out_pc          = fq_pc[fq_head];
        end else if (bypass) begin
            out_fetch_valid = 1'b1;
            out_insnbits    = in_imem_rdata;
            out_pc          = pcf[pcf_head];
        end
    end

    assign deq     = out_fetch_valid && !in_stall;
    assign pop     = deq && (fq_count != '0);
    assign enq     = resp_live && !(bypass && !in_stall);
    assign hlt_out = deq && (out_insnbits == HLT_INSN);

    assign out_imem_req_valid = req;
    assign out_imem_addr      = pc;
    assign out_fetch_done     = (state == DONE);

    always_comb begin
        state_n = state;
        if (state == IDLE) begin
            if (in_start && !in_redirect) state_n = RUN;
        end else begin
            if (hlt_in && state == RUN) state_n = DRAIN;
            if (hlt_out)                state_n = DONE;
            if (redirect)               state_n = RUN;
        end
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            fq_head     <= '0;
            fq_tail     <= '0;
            fq_count    <= '0;
            pcf_head    <= '0;
            pcf_tail    <= '0;
            outstanding <= '0;
            squash      <= '0;
        end else begin
            state <= state_n;
            if (req)                pcf_tail <= pcf_tail + 1'b1;
            if (in_imem_resp_valid) pcf_head <= pcf_head + 1'b1;
            outstanding <= outstanding + CW'(req) - CW'(in_imem_resp_valid);

            // Everything still in flight after a redirect or HLT belongs to a dead stream.
            if (redirect)
                squash <= outstanding - CW'(in_imem_resp_valid);
            else if (hlt_in)
                squash <= outstanding - 1'b1;
            else if (in_imem_resp_valid && squash != '0)
                squash <= squash - 1'b1;

            if (redirect)
                pc <= in_redirect_pc & ~64'd3;
            else if (req)
                pc <= pc + 64'd4;

            if (redirect) begin
                fq_head  <= '0;
                fq_tail  <= '0;
                fq_count <= '0;
            end else begin
                if (enq) fq_tail <= fq_tail + 1'b1;
                if (pop) fq_head <= fq_head + 1'b1;
                fq_count <= fq_count + CW'(enq) - CW'(pop);
            end
        end
    end

    always_ff @(posedge in_clk) begin
        if (req) pcf[pcf_tail] <= pc;
        if (enq && !redirect) begin
            fq_insn[fq_tail] <= in_imem_rdata;
            fq_pc[fq_tail]   <= pcf[pcf_head];
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: in-order memory model with random latency, scoreboard of the expected instruction stream.
module tb_fetch_unit;
    localparam int D = 4;
    localparam logic [31:0] HLT = 32'hD440_0000;
`ifdef FETCH_BYPASS_EN
    localparam longint FIRST_LAT = 1;
`else
    localparam longint FIRST_LAT = 2;
`endif

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_start = 1'b0, in_imem_resp_valid = 1'b0, in_stall = 1'b0, in_redirect = 1'b0;
    logic [31:0] in_imem_rdata = '0;
    logic [63:0] in_redirect_pc = '0;
    logic        out_imem_req_valid, out_fetch_valid, out_fetch_done;
    logic [63:0] out_imem_addr, out_pc;
    logic [31:0] out_insnbits;

    always #5 clk = ~clk;

    fetch_unit #(.FQ_DEPTH(D)) dut (
        .in_clk(clk), .in_rst(rst_n), .in_start(in_start),
        .out_imem_req_valid(out_imem_req_valid), .out_imem_addr(out_imem_addr),
        .in_imem_resp_valid(in_imem_resp_valid), .in_imem_rdata(in_imem_rdata),
        .out_fetch_valid(out_fetch_valid), .out_insnbits(out_insnbits), .out_pc(out_pc),
        .in_stall(in_stall), .out_fetch_done(out_fetch_done),
        .in_redirect(in_redirect), .in_redirect_pc(in_redirect_pc)
    );

    typedef struct { logic [63:0] addr; logic [31:0] data; longint due; } mreq_t;
    typedef struct { logic [63:0] pc; logic [31:0] insn; } exp_t;
    mreq_t mq[$];
    exp_t  sb[$];

    longint      cyc = 0, last_due = 0, first_req_cyc = -1, first_val_cyc = -1, hlt_cyc = -1;
    int          checks = 0, failures = 0;
    int          lat_min = 1, lat_max = 1, stall_pct = 0;
    logic [63:0] hlt_addr = 64'h20, req_exp = '0, prev_pc = '0;
    logic [31:0] prev_i = '0;
    bit          started = 0, done_exp = 0, done_next = 0, prev_v = 0, prev_s = 0, prev_r = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(logic [63:0] a);
        return (a == hlt_addr) ? HLT : {8'h91, a[25:2]};
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Program order from pc until (and including) the HLT word.
    task automatic push_stream(logic [63:0] start_pc);
        exp_t e;
        sb.delete();
        for (int i = 0; i < 256; i++) begin
            e.pc   = start_pc + 64'(4 * i);
            e.insn = mem_word(e.pc);
            sb.push_back(e);
            if (e.insn == HLT) break;
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
        in_start    = 1'b0;
        in_redirect = 1'b0;
        in_stall    = ($urandom_range(0, 99) < stall_pct);
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_start();
        in_start = 1'b1;
        step();
        started = 1;
        push_stream(64'h0);
        req_exp = 64'h0;
    endtask

    task automatic do_redirect(logic [63:0] npc);
        in_redirect    = 1'b1;
        in_redirect_pc = npc | 64'($urandom_range(0, 3));
        step();
        push_stream(npc);
        req_exp = npc;
    endtask

    task automatic check_outputs_zero(string tag);
        chk({tag, "_valid"}, 64'(out_fetch_valid), 64'd0);
        chk({tag, "_insn"},  64'(out_insnbits), 64'd0);
        chk({tag, "_pc"},    out_pc, 64'd0);
        chk({tag, "_done"},  64'(out_fetch_done), 64'd0);
        chk({tag, "_req"},   64'(out_imem_req_valid), 64'd0);
        chk({tag, "_addr"},  out_imem_addr, 64'd0);
    endtask

    task automatic end_of_stream(string tag);
        chk({tag, "_done"}, 64'(out_fetch_done), 64'd1);
        chk({tag, "_left"}, 64'(sb.size()), 64'd0);
    endtask

    // Memory: answers in request order after a random latency.
    initial begin : memory
        forever begin
            @(posedge clk); #1;
            in_imem_resp_valid = 1'b0;
            if (rst_n && mq.size() > 0 && mq[0].due <= cyc) begin
                in_imem_resp_valid = 1'b1;
                in_imem_rdata      = mq[0].data;
                void'(mq.pop_front());
            end
        end
    end

    initial begin : monitor
        exp_t   e;
        mreq_t  m;
        longint due;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 0;
            end else begin
                if (done_exp) begin
                    chk("done_high", 64'(out_fetch_done), 64'd1);
                    chk("done_no_valid", 64'(out_fetch_valid), 64'd0);
                    chk("done_no_req", 64'(out_imem_req_valid), 64'd0);
                end else begin
                    chk("done_low", 64'(out_fetch_done), 64'd0);
                end
                if (in_redirect) chk("req_in_redirect", 64'(out_imem_req_valid), 64'd0);
                if (!started)    chk("idle_no_req", 64'(out_imem_req_valid), 64'd0);
                if (out_imem_req_valid) begin
                    chk("req_addr", out_imem_addr, req_exp);
                    req_exp = req_exp + 64'd4;
                    if (first_req_cyc < 0) first_req_cyc = cyc;
                    due = cyc + longint'($urandom_range(lat_min, lat_max));
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    m.addr = out_imem_addr;
                    m.data = mem_word(out_imem_addr);
                    m.due  = due;
                    mq.push_back(m);
                    chk("credit", 64'(mq.size() <= D), 64'd1);
                end
                if (prev_v && prev_s && !prev_r) begin
                    chk("stall_hold_valid", 64'(out_fetch_valid), 64'd1);
                    chk("stall_hold_pc", out_pc, prev_pc);
                    chk("stall_hold_insn", 64'(out_insnbits), 64'(prev_i));
                end
                if (out_fetch_valid && first_val_cyc < 0) first_val_cyc = cyc;
                if (out_fetch_valid && !in_stall) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL xfer_unexpected actual_pc=%h required=no_transfer", out_pc);
                    end else begin
                        e = sb.pop_front();
                        chk("xfer_pc", out_pc, e.pc);
                        chk("xfer_insn", 64'(out_insnbits), 64'(e.insn));
                        if (e.insn == HLT) begin
                            hlt_cyc = cyc;
                            if (!in_redirect) done_next = 1;
                        end
                    end
                end
                if (done_next) done_exp = 1;
                done_next = 0;
                if (in_redirect) done_exp = 0;
                prev_v  = out_fetch_valid;
                prev_s  = in_stall;
                prev_r  = in_redirect;
                prev_pc = out_pc;
                prev_i  = out_insnbits;
            end
        end
    end

    initial begin : driver
        logic [63:0] base;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;
        step();

        // Latency 1, no stall: first-word latency and one instruction per cycle.
        hlt_addr = 64'h20; lat_min = 1; lat_max = 1; stall_pct = 0;
        do_start();
        run(30);
        chk("first_latency", 64'(first_val_cyc - first_req_cyc), 64'(FIRST_LAT));
        chk("throughput", 64'(hlt_cyc - first_val_cyc), 64'd8);
        end_of_stream("p1");

        // Redirect out of DONE resumes fetching.
        hlt_addr = 64'h3C;
        do_redirect(64'h1C);
        run(30);
        end_of_stream("from_done");

        // Long stall with a full credit window.
        hlt_addr = 64'h1000; lat_min = 1; lat_max = 2;
        do_redirect(64'h100);
        run(4);
        stall_pct = 100; run(5);
        stall_pct = 0;   run(12);

        // Latency 3 with requests in flight, then redirect.
        lat_min = 3; lat_max = 3;
        run(2);
        hlt_addr = 64'h58;
        do_redirect(64'h40);
        run(40);
        end_of_stream("lat3_redirect");

        for (int k = 0; k < 12; k++) begin
            lat_min   = 1;
            lat_max   = $urandom_range(1, 4);
            stall_pct = $urandom_range(0, 50);
            base      = 64'h2000 + 64'($urandom_range(0, 1023)) * 4;
            hlt_addr  = base + 64'($urandom_range(0, 20)) * 4;
            do_redirect(base);
            if ($urandom_range(0, 1) == 1) begin
                run($urandom_range(2, 8));
                base     = 64'h8000 + 64'($urandom_range(0, 1023)) * 4;
                hlt_addr = base + 64'($urandom_range(0, 20)) * 4;
                do_redirect(base);
            end
            run(200);
            end_of_stream("random");
        end

        // Reset with instructions sitting in the queue.
        lat_min = 1; lat_max = 1; stall_pct = 0; hlt_addr = 64'h10000;
        do_redirect(64'h300);
        run(4);
        stall_pct = 100; run(6);
        #2;
        rst_n = 1'b0;
        in_imem_resp_valid = 1'b0;
        #1;
        check_outputs_zero("mid_reset");
        mq.delete(); sb.delete();
        started = 0; done_exp = 0; done_next = 0; last_due = cyc;
        stall_pct = 0; in_stall = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();
        hlt_addr = 64'h10;
        do_start();
        run(30);
        end_of_stream("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Front end of the Tomasulo pipeline: produces the instruction stream that dispatch consumes as `in_insnbits` / `in_fetch_done`.
- Holds the PC and issues word reads to instruction memory, pipelined with credit control.
- Buffers returned instructions in a small in-order queue and presents them to dispatch under a valid/stall handshake.
- Squashes in-flight work on a mispredict redirect from the ROB, and stops fetching after an HLT instruction.

Parameters:
- FQ_DEPTH, 4: fetch-queue entries; power of two, ≥2.
- RESET_PC, 64'h0: PC loaded at reset.
- HLT_INSN, 32'hD440_0000: encoding that ends the fetch stream (A64 HLT #0).

Ports:
- in_clk  input  1  core clock.
- in_rst  input  1  reset, asynchronous, active-low.
- in_start  input  1  one-cycle pulse; begin fetching from the current PC.
- out_imem_req_valid  output  1  instruction read request this cycle.
- out_imem_addr  output  64  byte PC of the request, 4-byte aligned.
- in_imem_resp_valid  input  1  read data returns this cycle; responses come back in request order, latency ≥1.
- in_imem_rdata  input  32  returned instruction word.
- out_fetch_valid  output  1  out_insnbits/out_pc hold a valid instruction.
- out_insnbits  output  32  instruction to dispatch.
- out_pc  output  64  PC of out_insnbits.
- in_stall  input  1  dispatch cannot accept this cycle (driven from dispatch out_stalled).
- out_fetch_done  output  1  HLT was delivered to dispatch; the stream has ended.
- in_redirect  input  1  ROB mispredict: squash everything and refetch.
- in_redirect_pc  input  64  new PC; bits [1:0] are ignored.

Behaviour:
- Reset (async, in_rst=0):
  - state=IDLE, pc=RESET_PC, queue empty, outstanding=0, squash=0.
  - All outputs 0; out_imem_addr=RESET_PC.
- States:
  - IDLE: no requests. in_start → RUN.
  - RUN: issue requests.
  - DRAIN: HLT enqueued; no new requests; deliver the remaining queue.
  - DONE: HLT handed to dispatch; out_fetch_done=1 (held); out_fetch_valid=0.
- Request rule (RUN only): out_imem_req_valid=1 iff fq_count + outstanding < FQ_DEPTH, with no redirect this cycle.
  - On issue: out_imem_addr=pc; pc += 4 the next cycle.
  - outstanding increments on issue and decrements on each response.
- Response handling:
  - If squash>0: drop the response and decrement squash.
  - Otherwise: enqueue {rdata, pc_of_request}.
  - Request PCs are tracked by a FQ_DEPTH-entry PC FIFO parallel to outstanding requests.
  - If the enqueued word == HLT_INSN: RUN→DRAIN next cycle; requests stop immediately that cycle.
  - Responses to requests issued after the HLT request are squashed via the squash counter.
- Dispatch handshake:
  - Transfer occurs when out_fetch_valid && !in_stall; the queue head pops at the clock edge.
  - While in_stall=1, out_insnbits/out_pc/out_fetch_valid hold stable.
  - A transfer of HLT_INSN → DONE.
- Latency (bypass off): request at cycle t, response at t+L, out_fetch_valid at t+L+1.
- Throughput: one instruction per cycle when the memory sustains it.
- Full/empty:
  - The credit rule guarantees no overflow, including simultaneous enqueue and dequeue at full.
  - Queue empty → out_fetch_valid=0.
- Redirect (any state except IDLE; ignored in IDLE):
  - Next cycle: queue flushed, out_fetch_valid=0, pc=in_redirect_pc&~3, state=RUN, out_fetch_done=0.
  - squash = outstanding after accounting for any response in the redirect cycle. A response arriving in the redirect cycle is dropped.
  - No request is issued in the redirect cycle; the first new request goes out the cycle after.
- Redirect and in_start in the same cycle: redirect wins.
- Reset asserted mid-operation returns everything to reset values immediately.
- Memory responses arriving after reset, before any request, must not occur; behaviour in that case is undefined.

Optional Feature:
- FETCH_BYPASS_EN defined:
  - When the queue is empty and a non-squashed response arrives, it drives out_insnbits/out_pc/out_fetch_valid combinationally in the same cycle.
  - If in_stall=0, it is consumed without being enqueued; if in_stall=1, it is enqueued as usual.
  - Latency becomes t+L.
- Undefined: all responses pass through the queue (latency t+L+1); the outputs are purely registered.

Test Plan:
- Reset, in_start, memory latency 1, words 0x91000421 at PC 0/4/8, in_stall=0 → requests at addr 0,4,8 on consecutive cycles; out_fetch_valid at cycle 3 with out_insnbits=0x91000421, out_pc=0; one instruction per cycle afterwards.
- in_stall=1 for 5 cycles with FQ_DEPTH=4 → fq_count+outstanding never exceeds 4; out_imem_req_valid=0 once credits are exhausted; head is stable; after release, PCs are delivered in order with none lost or duplicated.
- Memory latency 3, two requests in flight, in_redirect=1 with in_redirect_pc=0x40 → both late responses are dropped; the next delivered instruction has out_pc=0x40; the first new request is at addr 0x40.
- Word at PC 8 is 0xD4400000 → no requests after the HLT; words at 0, 4, 8 are delivered; out_fetch_done=1 the cycle after HLT is accepted and stays high.
- From DONE, in_redirect with pc 0x1C → out_fetch_done=0, fetch resumes at 0x1C.
- Assert in_rst=0 mid-stream with 3 queued instructions → outputs are 0 asynchronously and the queue is empty. With FETCH_BYPASS_EN, an empty queue, in_stall=0 and latency 1: out_fetch_valid is high in the response cycle (t+1).
